seq_mul: RTL
============

Name: seq_mul

Overview:
- Iterative shift-and-add unsigned multiplier for the red-lava arithmetic datapath.
- Sits directly upstream of the result consumer and wraps a single WIDTH-bit ripple adder stage, which it drives once per cycle.
- Accepts one operand pair via valid/ready, runs WIDTH iterations, then presents a 2*WIDTH-bit product via valid/ready.
- Trades latency for area: one adder instead of a WIDTH x WIDTH array.

Parameters:
- WIDTH, 16, operand width in bits; product is 2*WIDTH bits; legal range 2..64.

Ports:
- clock  input  1  sole clock; all state updates on the rising edge.
- aclr_n  input  1  asynchronous active-low reset.
- clken  input  1  clock enable; when low, all state is frozen.
- in_valid  input  1  operand pair offered.
- in_ready  output  1  block can accept an operand pair.
- dataa  input  WIDTH  multiplicand.
- datab  input  WIDTH  multiplier.
- out_valid  output  1  result holds a valid product.
- out_ready  input  1  consumer takes the product.
- result  output  2*WIDTH  unsigned product dataa*datab.
- busy  output  1  high in RUN or DONE.

Behaviour:
- Reset is asynchronous and active-low on aclr_n; clock is the single clock.
- Values while aclr_n is low:
  - state = IDLE, in_ready = 0, out_valid = 0, result = 0, busy = 0.
  - All internal registers (mcand, acc_hi, acc_lo, count) = 0.
- in_ready = (state==IDLE) & clken & aclr_n. It is combinational, so it is 0 while clken is low.
- State IDLE:
  - On an edge with in_valid & in_ready: mcand <= dataa, acc_lo <= datab, acc_hi <= 0, count <= WIDTH-1, then go to RUN.
- State RUN (one iteration per enabled edge):
  - sum = acc_hi + (acc_lo[0] ? mcand : 0), computed WIDTH+1 bits wide with carry-out.
  - {acc_hi, acc_lo} <= {cout, sum[WIDTH-1:0], acc_lo[WIDTH-1:1]}.
  - If count==0, go to DONE; else count <= count-1.
- State DONE:
  - out_valid = 1; result = {acc_hi, acc_lo}, registered and stable while waiting.
  - On an enabled edge with out_ready=1: go to IDLE and clear out_valid.
  - While out_ready=0, result and out_valid hold indefinitely.
- Latency, with the accept edge counted as edge 0:
  - out_valid rises after edge WIDTH.
  - Minimum initiation interval is WIDTH+2 cycles. There is no accept in the same cycle as DONE handshake completion.
- clken low: no state, counter or data change. Latency stretches by exactly the number of disabled cycles.
- in_valid during RUN/DONE: ignored (in_ready=0), with no side effects.
- Arithmetic:
  - Unsigned only; the product always fits in 2*WIDTH bits, so there is no overflow output.
  - The adder carry-in is tied 0.
- Operand boundaries:
  - datab=0 or dataa=0: still takes the full WIDTH iterations; result = 0.
  - All-ones operands: result = 2^(2W) - 2^(W+1) + 1.
- Reset mid-operation: async clear to IDLE regardless of state. The partial product is discarded and out_valid falls immediately, without waiting for a clock edge.
- out_ready while not DONE: ignored.

Decomposition:
- Shared package arith_pkg:
  - state enum {IDLE, RUN, DONE}, encoded as 2 bits.
  - Function clog2 for the counter width, $clog2(WIDTH).
- One sub-module, mul_adder: a combinational WIDTH-bit adder with outputs {cout, sum}, carry-in 0.
  - Kept separate so the team's vendor adder primitive can be substituted for synthesis.
- Counter, state register and shift register remain in seq_mul.

Test Plan:
- WIDTH=16, dataa=3, datab=5 accepted at edge 0, out_ready=1 → out_valid rises after edge 16 with result=0x0000000F, then IDLE, in_ready=1 one cycle later.
- dataa=0xFFFF, datab=0xFFFF → result=0xFFFE0001.
- dataa=0x1234, datab=0 → result=0 after the full 16 iterations.
- dataa=0x8000, datab=0x8000 → result=0x40000000.
- Back-pressure: out_ready held 0 for 5 cycles after DONE → result and out_valid stable. in_valid pulses during this time are not accepted (in_ready=0); the product is released on the first edge with out_ready=1.
- clken low for 3 cycles in the middle of RUN on 7*9 → out_valid rises at edge 19 instead of 16, result=63.
- aclr_n pulsed low at RUN iteration 8 → out_valid, busy and result go to 0 asynchronously. After release, a new op 2*2 gives result=4 with nominal latency.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared types and helpers for the arithmetic datapath blocks.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned value);
    return $clog2(value);
  endfunction

endpackage

// File: rtl/mul_adder.sv
// Combinational WIDTH-bit adder with carry-out and carry-in tied low.
// A vendor adder primitive can replace this module for synthesis.
module mul_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/seq_mul.sv
// Iterative shift-and-add unsigned multiplier: one adder pass per enabled clock,
// WIDTH passes per product, valid/ready on both sides.
module seq_mul
  import arith_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clock,
  input  logic               aclr_n,
  input  logic               clken,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   dataa,
  input  logic [WIDTH-1:0]   datab,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               busy
);

  localparam int unsigned CntW = clog2(WIDTH);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]  acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]  acc_lo_q, acc_lo_d;
  logic [CntW-1:0]   count_q, count_d;

  logic [WIDTH-1:0]  addend;
  logic [WIDTH-1:0]  sum;
  logic              cout;

  // Low bit of the multiplier selects whether this pass adds the multiplicand.
  assign addend = acc_lo_q[0] ? mcand_q : '0;

  mul_adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a_i    (acc_hi_q),
    .b_i    (addend),
    .sum_o  (sum),
    .cout_o (cout)
  );

  assign in_ready  = (state_q == IDLE) & clken & aclr_n;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign result    = {acc_hi_q, acc_lo_q};

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    count_d  = count_q;
    if (clken) begin
      unique case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            mcand_d  = dataa;
            acc_lo_d = datab;
            acc_hi_d = '0;
            count_d  = CntW'(WIDTH - 1);
            state_d  = RUN;
          end
        end
        RUN: begin
          // Shift {cout, sum, acc_lo} right by one; the product fills in from the top.
          acc_hi_d = {cout, sum[WIDTH-1:1]};
          acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
          if (count_q == '0) begin
            state_d = DONE;
          end else begin
            count_d = count_q - 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      count_q  <= count_d;
    end
  end

endmodule
